// File: rtl/gm64_mem_pkg.sv
// Shared types for the memory arbiter: FSM states, channel ids, latched request word.
// No logic of its own; latency and backpressure are properties of the users.
package gm64_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  typedef enum logic {
    CH_CPU = 1'b0,
    CH_VIC = 1'b1
  } chan_t;

  localparam int BUSY_TIMEOUT_DEFAULT = 16;

  typedef struct packed {
    logic        we;
    logic [6:0]  bank;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU / VIC-II request channels, memory-controller port and error flags of mem_arbiter.
// master = requesters plus controller model, slave = the arbiter.
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [6:0]  cpu_bank;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;

  logic        vic_req;
  logic [6:0]  vic_bank;
  logic [15:0] vic_addr;
  logic        vic_ack;
  logic [7:0]  vic_rdata;

  logic        mc_ce;
  logic        mc_write;
  logic [6:0]  mc_bank;
  logic [15:0] mc_addr;
  logic [3:0]  mc_nbytes;
  logic [7:0]  mc_wdata;
  logic        mc_busy;
  logic [7:0]  mc_rdata;

  logic        err_timeout;
  logic        err_overrun;

  modport slave (
    input  cpu_req, cpu_we, cpu_bank, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  vic_req, vic_bank, vic_addr,
    output vic_ack, vic_rdata,
    output mc_ce, mc_write, mc_bank, mc_addr, mc_nbytes, mc_wdata,
    input  mc_busy, mc_rdata,
    output err_timeout, err_overrun
  );

  modport master (
    output cpu_req, cpu_we, cpu_bank, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output vic_req, vic_bank, vic_addr,
    input  vic_ack, vic_rdata,
    input  mc_ce, mc_write, mc_bank, mc_addr, mc_nbytes, mc_wdata,
    output mc_busy, mc_rdata,
    input  err_timeout, err_overrun
  );
endinterface

// File: rtl/mem_req_latch.sv
// One-deep pending slot per channel; strobe is also forwarded same-cycle (0-cycle bypass).
// No backpressure: a strobe into a full slot is dropped and flagged as overrun.
module mem_req_latch
  import gm64_mem_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     strobe,
  input  mem_req_t req_in,
  input  logic     clear,
  output logic     avail,
  output mem_req_t req_cur,
  output logic     overrun
);

  logic     pend_q;
  mem_req_t req_q;

  // A strobe coinciding with the completion of the current slot refills it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= 1'b0;
      req_q  <= '0;
    end else if (strobe && (!pend_q || clear)) begin
      pend_q <= 1'b1;
      req_q  <= req_in;
    end else if (clear) begin
      pend_q <= 1'b0;
    end
  end

  assign avail   = pend_q | strobe;
  assign req_cur = pend_q ? req_q : req_in;
  assign overrun = strobe & pend_q & ~clear;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin CPU/VIC-II arbiter onto a single-request memory controller; strobe->ack 4 clk minimum.
// Never issues while mc_busy is high; WAIT_BUSY gives up after BUSY_TIMEOUT cycles with rdata 8'hFF.
module mem_arbiter
  import gm64_mem_pkg::*;
#(
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

  state_t         state_q, state_nxt;
  chan_t          grant_q, last_grant_q, grant_nxt;
  logic [TW-1:0]  timer_q;
  logic           issue, done_ok, done_to;
  logic           cpu_avail, vic_avail, cpu_ovr, vic_ovr, cpu_clr, vic_clr;
  mem_req_t       cpu_in, vic_in, cpu_cur, vic_cur, issue_req;

  assign cpu_in = '{we: bus.cpu_we, bank: bus.cpu_bank, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
  assign vic_in = '{we: 1'b0, bank: bus.vic_bank, addr: bus.vic_addr, wdata: 8'h00};

  mem_req_latch u_cpu_latch (
    .clk(clk), .reset(reset), .strobe(bus.cpu_req), .req_in(cpu_in), .clear(cpu_clr),
    .avail(cpu_avail), .req_cur(cpu_cur), .overrun(cpu_ovr)
  );

  mem_req_latch u_vic_latch (
    .clk(clk), .reset(reset), .strobe(bus.vic_req), .req_in(vic_in), .clear(vic_clr),
    .avail(vic_avail), .req_cur(vic_cur), .overrun(vic_ovr)
  );

  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    issue     = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.mc_busy && (cpu_avail || vic_avail)) begin
          issue     = 1'b1;
          state_nxt = ST_ISSUE;
          if (cpu_avail && vic_avail)
            grant_nxt = (last_grant_q == CH_CPU) ? CH_VIC : CH_CPU;
          else
            grant_nxt = vic_avail ? CH_VIC : CH_CPU;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (bus.mc_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
          done_to   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.mc_busy) begin
          done_ok   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    issue_req = (grant_nxt == CH_VIC) ? vic_cur : cpu_cur;
  end

  assign cpu_clr   = (done_ok || done_to) && (grant_q == CH_CPU);
  assign vic_clr   = (done_ok || done_to) && (grant_q == CH_VIC);
  assign bus.mc_ce = (state_q == ST_ISSUE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      grant_q         <= CH_CPU;
      last_grant_q    <= CH_CPU;
      timer_q         <= '0;
      bus.mc_write    <= 1'b0;
      bus.mc_bank     <= '0;
      bus.mc_addr     <= '0;
      bus.mc_nbytes   <= '0;
      bus.mc_wdata    <= '0;
      bus.cpu_ack     <= 1'b0;
      bus.vic_ack     <= 1'b0;
      bus.cpu_rdata   <= '0;
      bus.vic_rdata   <= '0;
      bus.err_timeout <= 1'b0;
      bus.err_overrun <= 1'b0;
    end else begin
      state_q <= state_nxt;
      timer_q <= (state_q == ST_WAIT_BUSY) ? timer_q + TW'(1) : '0;
      // Command fields are captured once and held for the whole transaction.
      if (issue) begin
        grant_q       <= grant_nxt;
        last_grant_q  <= grant_nxt;
        bus.mc_write  <= issue_req.we;
        bus.mc_bank   <= issue_req.bank;
        bus.mc_addr   <= issue_req.addr;
        bus.mc_nbytes <= 4'd1;
        bus.mc_wdata  <= issue_req.wdata;
      end
      bus.cpu_ack <= cpu_clr;
      bus.vic_ack <= vic_clr;
      if (cpu_clr) begin
        if (done_to)            bus.cpu_rdata <= 8'hFF;
        else if (!bus.mc_write) bus.cpu_rdata <= bus.mc_rdata;
      end
      if (vic_clr) bus.vic_rdata <= done_to ? 8'hFF : bus.mc_rdata;
      bus.err_timeout <= bus.err_timeout | done_to;
      bus.err_overrun <= bus.err_overrun | cpu_ovr | vic_ovr;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: controller model with programmable busy length,
// inputs driven and outputs sampled on the falling edge.
module tb_mem_arbiter;
  import gm64_mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.BUSY_TIMEOUT(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic       force_busy = 1'b0;
  logic       model_busy = 1'b0;
  logic       model_en = 1'b1;
  int         busy_len = 1;
  int         model_left = 0;
  logic [7:0] model_rdata = 8'h00;

  assign bus.mc_busy  = force_busy | model_busy;
  assign bus.mc_rdata = model_rdata;

  // Controller model: busy for busy_len cycles starting the cycle after mc_ce.
  always @(posedge clk) begin
    if (bus.mc_ce && model_en) begin
      model_busy <= 1'b1;
      model_left <= busy_len;
    end else if (model_left > 1) begin
      model_left <= model_left - 1;
    end else begin
      model_busy <= 1'b0;
      model_left <= 0;
    end
  end

  logic cnt_clr = 1'b0;
  int   ce_cnt = 0, cack_cnt = 0, vack_cnt = 0;

  always @(posedge clk) begin
    if (cnt_clr) begin
      ce_cnt   <= 0;
      cack_cnt <= 0;
      vack_cnt <= 0;
    end else begin
      if (bus.mc_ce)   ce_cnt   <= ce_cnt + 1;
      if (bus.cpu_ack) cack_cnt <= cack_cnt + 1;
      if (bus.vic_ack) vack_cnt <= vack_cnt + 1;
    end
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_strobe(input logic we, input logic [6:0] bank, input logic [15:0] addr,
                            input logic [7:0] wdata);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_bank = bank;
    bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    @(negedge clk);
    bus.cpu_req = 1'b0;
  endtask

  task automatic vic_strobe(input logic [6:0] bank, input logic [15:0] addr);
    bus.vic_req = 1'b1; bus.vic_bank = bank; bus.vic_addr = addr;
    @(negedge clk);
    bus.vic_req = 1'b0;
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_bank = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vic_req = 1'b0; bus.vic_bank = '0; bus.vic_addr = '0;
    force_busy = 1'b1;
    cycles(2);

    // Reset values
    check("rst_mc_ce", bus.mc_ce, 0);
    check("rst_mc_write", bus.mc_write, 0);
    check("rst_mc_bank", bus.mc_bank, 0);
    check("rst_mc_addr", bus.mc_addr, 0);
    check("rst_mc_nbytes", bus.mc_nbytes, 0);
    check("rst_mc_wdata", bus.mc_wdata, 0);
    check("rst_cpu_ack", bus.cpu_ack, 0);
    check("rst_vic_ack", bus.vic_ack, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_vic_rdata", bus.vic_rdata, 0);
    check("rst_err_timeout", bus.err_timeout, 0);
    check("rst_err_overrun", bus.err_overrun, 0);
    check("rst_state", dut.state_q, ST_IDLE);

    // Controller init: busy held for ~15000 cycles, request at cycle 10
    reset = 1'b0;
    clr_cnt();
    cycles(9);
    cpu_strobe(1'b0, 7'd1, 16'h0010, 8'h00);
    cycles(14980);
    check("init_no_issue", ce_cnt, 0);
    check("init_mc_ce_low", bus.mc_ce, 0);
    model_rdata = 8'h3C;
    force_busy = 1'b0;
    cycles(1);
    check("init_issue_ce", bus.mc_ce, 1);
    check("init_issue_bank", bus.mc_bank, 7'd1);
    check("init_issue_addr", bus.mc_addr, 16'h0010);
    cycles(3);
    check("init_cpu_ack", bus.cpu_ack, 1);
    check("init_cpu_rdata", bus.cpu_rdata, 8'h3C);

    // Single CPU read, minimum latency, then a strobe on the ack-generating cycle
    pulse_reset();
    model_rdata = 8'hA5;
    clr_cnt();
    cpu_strobe(1'b0, 7'd3, 16'h1234, 8'h00);
    check("rd_mc_ce", bus.mc_ce, 1);
    check("rd_mc_bank", bus.mc_bank, 7'd3);
    check("rd_mc_addr", bus.mc_addr, 16'h1234);
    check("rd_mc_write", bus.mc_write, 0);
    check("rd_mc_nbytes", bus.mc_nbytes, 4'd1);
    cycles(2);
    check("rd_ack_not_early", bus.cpu_ack, 0);
    cpu_strobe(1'b0, 7'd6, 16'hBEEF, 8'h00);
    check("rd_cpu_ack", bus.cpu_ack, 1);
    check("rd_cpu_rdata", bus.cpu_rdata, 8'hA5);
    cycles(1);
    check("refill_no_overrun", bus.err_overrun, 0);
    check("refill_mc_ce", bus.mc_ce, 1);
    check("refill_mc_bank", bus.mc_bank, 7'd6);
    check("refill_mc_addr", bus.mc_addr, 16'hBEEF);
    model_rdata = 8'h5C;
    cycles(3);
    check("refill_cpu_ack", bus.cpu_ack, 1);
    check("refill_cpu_rdata", bus.cpu_rdata, 8'h5C);
    check("refill_ce_count", ce_cnt, 2);

    // Simultaneous CPU/VIC after reset: VIC first
    pulse_reset();
    clr_cnt();
    model_rdata = 8'h96;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_bank = 7'd5; bus.cpu_addr = 16'h0505;
    bus.vic_req = 1'b1; bus.vic_bank = 7'd2; bus.vic_addr = 16'h2222;
    cycles(1);
    bus.cpu_req = 1'b0; bus.vic_req = 1'b0;
    check("tie_first_bank", bus.mc_bank, 7'd2);
    check("tie_first_addr", bus.mc_addr, 16'h2222);
    check("tie_first_write", bus.mc_write, 0);
    cycles(3);
    check("tie_vic_ack", bus.vic_ack, 1);
    check("tie_vic_rdata", bus.vic_rdata, 8'h96);
    check("tie_cpu_ack_wait", bus.cpu_ack, 0);
    cycles(1);
    check("tie_second_ce", bus.mc_ce, 1);
    check("tie_second_bank", bus.mc_bank, 7'd5);
    model_rdata = 8'h77;
    cycles(3);
    check("tie_cpu_ack", bus.cpu_ack, 1);
    check("tie_cpu_rdata", bus.cpu_rdata, 8'h77);
    check("tie_vic_rdata_held", bus.vic_rdata, 8'h96);
    cycles(1);
    check("tie_ce_count", ce_cnt, 2);
    check("tie_cpu_acks", cack_cnt, 1);
    check("tie_vic_acks", vack_cnt, 1);
    check("tie_no_overrun", bus.err_overrun, 0);
    check("tie_no_timeout", bus.err_timeout, 0);

    // Overrun: second CPU strobe while the first (a write) is pending
    clr_cnt();
    cpu_strobe(1'b1, 7'd1, 16'h0100, 8'h5A);
    check("ovr_mc_write", bus.mc_write, 1);
    check("ovr_mc_wdata", bus.mc_wdata, 8'h5A);
    check("ovr_mc_bank", bus.mc_bank, 7'd1);
    cpu_strobe(1'b0, 7'd7, 16'h0707, 8'h00);
    check("ovr_flag", bus.err_overrun, 1);
    cycles(10);
    check("ovr_ce_count", ce_cnt, 1);
    check("ovr_ack_count", cack_cnt, 1);
    check("ovr_wr_rdata_kept", bus.cpu_rdata, 8'h77);
    check("ovr_bank_held", bus.mc_bank, 7'd1);

    // Busy timeout
    model_en = 1'b0;
    clr_cnt();
    cpu_strobe(1'b0, 7'd2, 16'h4444, 8'h00);
    check("to_mc_ce", bus.mc_ce, 1);
    cycles(16);
    check("to_ack_not_early", bus.cpu_ack, 0);
    check("to_flag_not_early", bus.err_timeout, 0);
    cycles(1);
    check("to_cpu_ack", bus.cpu_ack, 1);
    check("to_cpu_rdata", bus.cpu_rdata, 8'hFF);
    check("to_err_timeout", bus.err_timeout, 1);
    check("to_state_idle", dut.state_q, ST_IDLE);
    check("to_overrun_sticky", bus.err_overrun, 1);

    // Reset while waiting for the controller to finish
    model_en = 1'b1;
    busy_len = 5;
    model_rdata = 8'h11;
    clr_cnt();
    cpu_strobe(1'b0, 7'd4, 16'h0F0F, 8'h00);
    cycles(2);
    check("mid_state_wait_done", dut.state_q, ST_WAIT_DONE);
    reset = 1'b1;
    #1;
    check("mid_rst_mc_ce", bus.mc_ce, 0);
    check("mid_rst_cpu_ack", bus.cpu_ack, 0);
    check("mid_rst_cpu_slot", dut.u_cpu_latch.pend_q, 0);
    check("mid_rst_vic_slot", dut.u_vic_latch.pend_q, 0);
    check("mid_rst_err_timeout", bus.err_timeout, 0);
    check("mid_rst_err_overrun", bus.err_overrun, 0);
    cycles(1);
    reset = 1'b0;
    clr_cnt();
    cycles(10);
    check("mid_no_ack", cack_cnt, 0);
    check("mid_no_reissue", ce_cnt, 0);
    busy_len = 1;
    model_rdata = 8'hC3;
    vic_strobe(7'h55, 16'hABCD);
    check("post_mc_ce", bus.mc_ce, 1);
    check("post_mc_bank", bus.mc_bank, 7'h55);
    check("post_mc_addr", bus.mc_addr, 16'hABCD);
    cycles(3);
    check("post_vic_ack", bus.vic_ack, 1);
    check("post_vic_rdata", bus.vic_rdata, 8'hC3);
    check("post_no_errors", {bus.err_timeout, bus.err_overrun}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
